// File: rtl/eb_fifo_pkg.sv
// Shared helpers for the elastic FIFO: counter/pointer widths and wrap-aware
// pointer increment for depths that need not be powers of two.
package eb_pkg;

  localparam int unsigned EB_DEF_DEPTH = 4;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 32'd0 : ptr + 1;
  endfunction

endpackage

// File: rtl/eb_fifo_if.sv
// Handshake bundle for the FIFO: target (t_0) side in, initiator (i_0) side out.
// Transfer happens on a rising edge where valid and ready are both high; the
// producer holds data stable while valid=1 and ready=0, and never waits on ready.
interface eb_fifo_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] t_0_data;
  logic             t_0_valid;
  logic             t_0_ready;
  logic [WIDTH-1:0] i_0_data;
  logic             i_0_valid;
  logic             i_0_ready;

  modport slave (
    input  t_0_data, t_0_valid, i_0_ready,
    output t_0_ready, i_0_data, i_0_valid
  );

  modport master (
    output t_0_data, t_0_valid, i_0_ready,
    input  t_0_ready, i_0_data, i_0_valid
  );
endinterface

// File: rtl/eb_fifo_ctrl.sv
// Pointer/occupancy control for the elastic FIFO. Ready, valid and almost_full
// are registered from the next count so neither side sees a combinational path.
module eb_fifo_ctrl
  import eb_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AFULL = DEPTH - 1,
  localparam int CW    = cnt_w(DEPTH),
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          t_0_valid,
  output logic          t_0_ready,
  output logic          i_0_valid,
  input  logic          i_0_ready,
  output logic [CW-1:0] level,
  output logic          almost_full,
  output logic          en_wr,
  output logic          en_rd,
  output logic [PW-1:0] wp,
  output logic [PW-1:0] rp
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic          r_ready;
  logic          r_valid;
  logic          r_afull;
  logic          w_push;
  logic          w_pop;

  assign w_push = t_0_valid & r_ready;
  assign w_pop  = r_valid & i_0_ready;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_afull <= (AFULL == 0);
    end else begin
      r_cnt   <= w_cnt_nxt;
      if (w_push) r_wp <= PW'(ptr_inc(32'(r_wp), DEPTH));
      if (w_pop)  r_rp <= PW'(ptr_inc(32'(r_rp), DEPTH));
      r_ready <= (w_cnt_nxt < CW'(DEPTH));
      r_valid <= (w_cnt_nxt != '0);
      r_afull <= (w_cnt_nxt >= CW'(AFULL));
    end
  end

  assign t_0_ready   = r_ready;
  assign i_0_valid   = r_valid;
  assign level       = r_cnt;
  assign almost_full = r_afull;
  assign en_wr       = w_push;
  assign en_rd       = w_pop;
  assign wp          = r_wp;
  assign rp          = r_rp;

endmodule

// File: rtl/eb_fifo.sv
// Elastic FIFO stage: circular storage array driven by eb_fifo_ctrl. Head data
// is read directly at the read pointer; storage itself is never reset.
module eb_fifo
  import eb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = EB_DEF_DEPTH,
  parameter int AFULL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  eb_fifo_if.slave                   bus,
  output logic [cnt_w(DEPTH)-1:0]    level,
  output logic                       almost_full
);

  localparam int PW = ptr_w(DEPTH);

  logic             w_en_wr;
  logic             w_en_rd;
  logic [PW-1:0]    w_wp;
  logic [PW-1:0]    w_rp;
  logic [WIDTH-1:0] r_mem [DEPTH];

  eb_fifo_ctrl #(
    .DEPTH (DEPTH),
    .AFULL (AFULL)
  ) u_ctrl (
    .clk         (clk),
    .reset_n     (reset_n),
    .t_0_valid   (bus.t_0_valid),
    .t_0_ready   (bus.t_0_ready),
    .i_0_valid   (bus.i_0_valid),
    .i_0_ready   (bus.i_0_ready),
    .level       (level),
    .almost_full (almost_full),
    .en_wr       (w_en_wr),
    .en_rd       (w_en_rd),
    .wp          (w_wp),
    .rp          (w_rp)
  );

  always_ff @(posedge clk) begin
    if (w_en_wr) r_mem[w_wp] <= bus.t_0_data;
  end

  // en_rd only moves the read pointer; the head is always the entry at rp.
  assign bus.i_0_data = r_mem[w_rp];

endmodule

// File: tb/tb_eb_fifo.sv
// Directed bench for eb_fifo: DEPTH=4/AFULL=3 and DEPTH=3/AFULL=2 instances
// driven independently through the same scenario tasks.
module tb_eb_fifo;

  logic       clk;
  logic       rst_n [2];
  logic       tv    [2];
  logic [7:0] td    [2];
  logic       ir    [2];
  logic       o_tr  [2];
  logic       o_iv  [2];
  logic [7:0] o_id  [2];
  logic [2:0] o_lvl [2];
  logic       o_af  [2];

  logic [2:0] lvl0;
  logic [1:0] lvl1;
  logic       af0, af1;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q [$];

  eb_fifo_if #(.WIDTH(8)) bus0 ();
  eb_fifo_if #(.WIDTH(8)) bus1 ();

  eb_fifo #(.WIDTH(8), .DEPTH(4), .AFULL(3)) dut0 (
    .clk(clk), .reset_n(rst_n[0]), .bus(bus0), .level(lvl0), .almost_full(af0)
  );
  eb_fifo #(.WIDTH(8), .DEPTH(3), .AFULL(2)) dut1 (
    .clk(clk), .reset_n(rst_n[1]), .bus(bus1), .level(lvl1), .almost_full(af1)
  );

  assign bus0.t_0_valid = tv[0];
  assign bus0.t_0_data  = td[0];
  assign bus0.i_0_ready = ir[0];
  assign bus1.t_0_valid = tv[1];
  assign bus1.t_0_data  = td[1];
  assign bus1.i_0_ready = ir[1];
  assign o_tr[0]  = bus0.t_0_ready;
  assign o_iv[0]  = bus0.i_0_valid;
  assign o_id[0]  = bus0.i_0_data;
  assign o_lvl[0] = lvl0;
  assign o_af[0]  = af0;
  assign o_tr[1]  = bus1.t_0_ready;
  assign o_iv[1]  = bus1.i_0_valid;
  assign o_id[1]  = bus1.i_0_data;
  assign o_lvl[1] = {1'b0, lvl1};
  assign o_af[1]  = af1;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input int s);
    n_checks++;
    if (o_iv[s] !== 1'b0) begin n_errors++; $display("FAIL reset_valid[%0d] got %b want 0", s, o_iv[s]); end
    n_checks++;
    if (o_tr[s] !== 1'b1) begin n_errors++; $display("FAIL reset_ready[%0d] got %b want 1", s, o_tr[s]); end
    n_checks++;
    if (o_lvl[s] !== 3'd0) begin n_errors++; $display("FAIL reset_level[%0d] got %0d want 0", s, o_lvl[s]); end
    n_checks++;
    if (o_af[s] !== 1'b0) begin n_errors++; $display("FAIL reset_afull[%0d] got %b want 0", s, o_af[s]); end
  endtask

  task automatic test_fill(input int s, input int d, input int af);
    logic [7:0] v;
    ir[s] = 1'b0;
    for (int k = 0; k < d; k++) begin
      v = 8'(8'h11 * (k + 1));
      tv[s] = 1'b1;
      td[s] = v;
      cyc();
      n_checks++;
      if (o_lvl[s] !== 3'(k + 1)) begin n_errors++; $display("FAIL fill_level[%0d] k=%0d got %0d want %0d", s, k, o_lvl[s], k + 1); end
      n_checks++;
      if (o_af[s] !== ((k + 1) >= af)) begin n_errors++; $display("FAIL fill_afull[%0d] k=%0d got %b want %b", s, k, o_af[s], (k + 1) >= af); end
      n_checks++;
      if (o_tr[s] !== ((k + 1) < d)) begin n_errors++; $display("FAIL fill_ready[%0d] k=%0d got %b want %b", s, k, o_tr[s], (k + 1) < d); end
    end
    td[s] = 8'h55;
    cyc();
    cyc();
    n_checks++;
    if (o_lvl[s] !== 3'(d)) begin n_errors++; $display("FAIL full_level[%0d] got %0d want %0d", s, o_lvl[s], d); end
    n_checks++;
    if (o_tr[s] !== 1'b0) begin n_errors++; $display("FAIL full_ready[%0d] got %b want 0", s, o_tr[s]); end
    n_checks++;
    if (o_iv[s] !== 1'b1 || o_id[s] !== 8'h11) begin n_errors++; $display("FAIL full_head[%0d] got %b/%h want 1/11", s, o_iv[s], o_id[s]); end
  endtask

  // 0x55 is still offered: it lands on the second edge, right behind the originals.
  task automatic test_drain(input int s, input int d);
    logic [7:0] e;
    ir[s] = 1'b1;
    for (int k = 0; k <= d; k++) begin
      e = (k == d) ? 8'h55 : 8'(8'h11 * (k + 1));
      n_checks++;
      if (o_iv[s] !== 1'b1 || o_id[s] !== e) begin n_errors++; $display("FAIL drain_head[%0d] k=%0d got %b/%h want 1/%h", s, k, o_iv[s], o_id[s], e); end
      if (k == 1) begin
        n_checks++;
        if (o_tr[s] !== 1'b1) begin n_errors++; $display("FAIL drain_ready[%0d] got %b want 1", s, o_tr[s]); end
      end
      if (k == 2) tv[s] = 1'b0;
      cyc();
    end
    n_checks++;
    if (o_iv[s] !== 1'b0 || o_lvl[s] !== 3'd0) begin n_errors++; $display("FAIL drain_empty[%0d] got %b/%0d want 0/0", s, o_iv[s], o_lvl[s]); end
    ir[s] = 1'b0;
  endtask

  task automatic test_stream(input int s);
    ir[s] = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      if (k >= 1) begin
        n_checks++;
        if (o_iv[s] !== 1'b1 || o_id[s] !== 8'(k - 1)) begin n_errors++; $display("FAIL stream_out[%0d] k=%0d got %b/%h want 1/%h", s, k, o_iv[s], o_id[s], 8'(k - 1)); end
        n_checks++;
        if (o_lvl[s] !== 3'd1 || o_tr[s] !== 1'b1) begin n_errors++; $display("FAIL stream_level[%0d] k=%0d got %0d/%b want 1/1", s, k, o_lvl[s], o_tr[s]); end
      end
      tv[s] = (k < 16);
      td[s] = 8'(k);
      cyc();
    end
    n_checks++;
    if (o_iv[s] !== 1'b0) begin n_errors++; $display("FAIL stream_end[%0d] got %b want 0", s, o_iv[s]); end
    ir[s] = 1'b0;
  endtask

  task automatic test_random(input int s, input int d);
    int   m_cnt = 0;
    bit   hold  = 1'b0;
    bit   e_tr;
    bit   psh, pop;
    exp_q.delete();
    for (int c = 0; c < 1000; c++) begin
      if (!hold) begin
        tv[s] = 1'($urandom_range(0, 1));
        td[s] = 8'($urandom_range(0, 255));
      end
      ir[s] = 1'($urandom_range(0, 1));
      #1;
      e_tr = (m_cnt < d);
      n_checks++;
      if (o_tr[s] !== e_tr) begin n_errors++; $display("FAIL rnd_ready[%0d] c=%0d got %b want %b", s, c, o_tr[s], e_tr); end
      n_checks++;
      if (o_iv[s] !== (m_cnt != 0)) begin n_errors++; $display("FAIL rnd_valid[%0d] c=%0d got %b want %b", s, c, o_iv[s], m_cnt != 0); end
      n_checks++;
      if (o_lvl[s] !== 3'(m_cnt)) begin n_errors++; $display("FAIL rnd_level[%0d] c=%0d got %0d want %0d", s, c, o_lvl[s], m_cnt); end
      if (m_cnt != 0) begin
        n_checks++;
        if (o_id[s] !== exp_q[0]) begin n_errors++; $display("FAIL rnd_data[%0d] c=%0d got %h want %h", s, c, o_id[s], exp_q[0]); end
      end
      psh = tv[s] & e_tr;
      pop = ir[s] & (m_cnt != 0);
      if (pop) void'(exp_q.pop_front());
      if (psh) exp_q.push_back(td[s]);
      m_cnt = m_cnt + int'(psh) - int'(pop);
      hold = tv[s] & ~e_tr;
      cyc();
    end
    tv[s] = 1'b0;
    ir[s] = 1'b1;
    for (int k = 0; k < d + 1; k++) cyc();
    ir[s] = 1'b0;
  endtask

  task automatic test_reset_mid(input int s);
    ir[s] = 1'b0;
    tv[s] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      td[s] = 8'(8'hC0 + k);
      cyc();
    end
    tv[s] = 1'b0;
    #2;
    rst_n[s] = 1'b0;
    #1;
    test_reset(s);
    @(negedge clk);
    rst_n[s] = 1'b1;
    tv[s] = 1'b1;
    td[s] = 8'hA5;
    cyc();
    tv[s] = 1'b0;
    n_checks++;
    if (o_iv[s] !== 1'b1 || o_id[s] !== 8'hA5 || o_lvl[s] !== 3'd1) begin
      n_errors++;
      $display("FAIL post_reset_head[%0d] got %b/%h/%0d want 1/a5/1", s, o_iv[s], o_id[s], o_lvl[s]);
    end
    ir[s] = 1'b1;
    cyc();
    ir[s] = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0;
      tv[s]    = 1'b0;
      td[s]    = 8'h00;
      ir[s]    = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    cyc();

    test_reset(0);
    test_reset(1);
    test_fill(0, 4, 3);
    test_drain(0, 4);
    test_stream(0);
    test_random(0, 4);
    test_reset_mid(0);
    test_fill(1, 3, 2);
    test_drain(1, 3);
    test_stream(1);
    test_random(1, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
